// File: rtl/cbus_arbiter_pkg.sv
// cbus_arbiter_pkg: cbus request/response types, AXI burst encodings and arbiter state
// shared by the cbus arbiter slice.
package cbus_arbiter_pkg;

    localparam int CBUS_ARB_MAX_MASTERS = 8;

    localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
    localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;

    typedef struct packed {
        logic        valid;
        logic        is_write;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [7:0]  len;
        logic [1:0]  burst;
        logic [63:0] data;
        logic [7:0]  strb;
    } cbus_req_t;

    typedef struct packed {
        logic        ready;
        logic        last;
        logic [63:0] data;
    } cbus_resp_t;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_t;

endpackage

// File: rtl/cbus_arb_pick.sv
// cbus_arb_pick: combinational winner search over a valid vector, starting at 'start'
// and wrapping modulo NUM_MASTERS; the first valid index found wins.
module cbus_arb_pick #(
    parameter int NUM_MASTERS = 2,
    parameter int IDX_W       = 1
) (
    input  logic [NUM_MASTERS-1:0] valid,
    input  logic [IDX_W-1:0]       start,
    output logic [IDX_W-1:0]       winner,
    output logic                   any_valid
);

    // Walk offsets from farthest to nearest so the nearest valid index is the last writer.
    always_comb begin
        logic [IDX_W-1:0] idx;
        idx       = '0;
        winner    = '0;
        any_valid = |valid;
        for (int off = NUM_MASTERS - 1; off >= 0; off--) begin
            idx = IDX_W'((int'(start) + off) % NUM_MASTERS);
            if (valid[idx]) begin
                winner = idx;
            end
        end
    end

endmodule

// File: rtl/cbus_arbiter.sv
// cbus_arbiter: merges NUM_MASTERS cbus masters onto the single memory-model port, one transaction per grant.
// Define CBUS_ARB_ROUND_ROBIN_EN for round-robin arbitration; otherwise the lowest valid index wins.
module cbus_arbiter
    import cbus_arbiter_pkg::*;
#(
    parameter int NUM_MASTERS = 2,
    parameter int IDX_W       = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  cbus_req_t        ireqs  [NUM_MASTERS],
    output cbus_resp_t       iresps [NUM_MASTERS],
    output cbus_req_t        oreq,
    input  cbus_resp_t       oresp,
    output logic             busy,
    output logic [IDX_W-1:0] grant_idx,
    output logic             proto_err
);

    localparam logic ST_IDLE = ARB_IDLE;
    localparam logic ST_BUSY = ARB_BUSY;

    logic                   state;
    logic [IDX_W-1:0]       grant_q;
    logic [7:0]             beat_cnt;
    logic [NUM_MASTERS-1:0] valid_vec;
    logic [IDX_W-1:0]       start_idx;
    logic [IDX_W-1:0]       pick_idx;
    logic                   pick_any;
    cbus_req_t              cur_req;
    logic                   snap_write;
    logic [31:0]            snap_addr;
    logic [2:0]             snap_size;
    logic [7:0]             snap_len;
    logic [1:0]             snap_burst;
    logic                   stable_bad;
    logic                   beat_bad;
    logic                   err_set;

    always_comb begin
        for (int i = 0; i < NUM_MASTERS; i++) begin
            valid_vec[i] = ireqs[i].valid;
        end
    end

    cbus_arb_pick #(
        .NUM_MASTERS(NUM_MASTERS),
        .IDX_W      (IDX_W)
    ) u_pick (
        .valid    (valid_vec),
        .start    (start_idx),
        .winner   (pick_idx),
        .any_valid(pick_any)
    );

`ifdef CBUS_ARB_ROUND_ROBIN_EN
    logic [IDX_W-1:0] rr_ptr;

    // Pointer names the master just after the most recent grant.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rr_ptr <= '0;
        end else if (state == ST_IDLE && pick_any) begin
            rr_ptr <= (pick_idx == IDX_W'(NUM_MASTERS - 1)) ? '0 : pick_idx + IDX_W'(1);
        end
    end

    assign start_idx = rr_ptr;
`else
    assign start_idx = '0;
`endif

    assign cur_req   = ireqs[grant_q];
    assign busy      = (state == ST_BUSY);
    assign grant_idx = grant_q;

    always_comb begin
        oreq = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            iresps[i] = '0;
        end
        if (state == ST_BUSY) begin
            oreq            = cur_req;
            iresps[grant_q] = oresp;
        end
    end

    // Granted request must match what was captured at grant time; beat count must line up with len.
    always_comb begin
        stable_bad = (state == ST_BUSY) &&
                     (!cur_req.valid || cur_req.is_write != snap_write ||
                      cur_req.addr != snap_addr || cur_req.size != snap_size ||
                      cur_req.len != snap_len || cur_req.burst != snap_burst);
        beat_bad   = (state == ST_BUSY) && oresp.ready &&
                     (oresp.last ? (beat_cnt != cur_req.len) : (beat_cnt >= cur_req.len));
        err_set    = stable_bad || beat_bad;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= ST_IDLE;
            grant_q    <= '0;
            beat_cnt   <= '0;
            proto_err  <= 1'b0;
            snap_write <= 1'b0;
            snap_addr  <= '0;
            snap_size  <= '0;
            snap_len   <= '0;
            snap_burst <= '0;
        end else begin
            if (err_set) begin
                proto_err <= 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    if (pick_any) begin
                        state      <= ST_BUSY;
                        grant_q    <= pick_idx;
                        beat_cnt   <= '0;
                        snap_write <= ireqs[pick_idx].is_write;
                        snap_addr  <= ireqs[pick_idx].addr;
                        snap_size  <= ireqs[pick_idx].size;
                        snap_len   <= ireqs[pick_idx].len;
                        snap_burst <= ireqs[pick_idx].burst;
                    end
                end
                default: begin
                    if (oresp.ready) begin
                        if (oresp.last) begin
                            state   <= ST_IDLE;
                            grant_q <= '0;
                        end else begin
                            beat_cnt <= beat_cnt + 8'd1;
                        end
                    end
                end
            endcase
        end
    end

`ifdef SIMULATION
    always_ff @(posedge clk) begin
        if (reset && err_set && !proto_err) begin
            $display("ERROR: cbus arbiter protocol violation, master %d", grant_q);
        end
    end
`endif

endmodule

// File: tb/tb_cbus_arbiter.sv
// tb_cbus_arbiter: directed scenarios plus randomized traffic against a transaction-level model
// of the arbiter (owner/pointer bookkeeping), for a 3-master cbus_arbiter.
module tb_cbus_arbiter;
    import cbus_arbiter_pkg::*;

    localparam int N  = 3;
    localparam int IW = 2;

    logic          clk;
    logic          reset;
    cbus_req_t     ireqs  [N];
    cbus_resp_t    iresps [N];
    cbus_req_t     oreq;
    cbus_resp_t    oresp;
    logic          busy;
    logic [IW-1:0] grant_idx;
    logic          proto_err;

    int errors;
    int checks;
    int tb_ptr;

    cbus_arbiter #(
        .NUM_MASTERS(N),
        .IDX_W      (IW)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .ireqs    (ireqs),
        .iresps   (iresps),
        .oreq     (oreq),
        .oresp    (oresp),
        .busy     (busy),
        .grant_idx(grant_idx),
        .proto_err(proto_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic cbus_req_t mk_req(input logic wr, input logic [31:0] addr, input logic [7:0] len);
        cbus_req_t r;
        r          = '0;
        r.valid    = 1'b1;
        r.is_write = wr;
        r.addr     = addr;
        r.size     = 3'd3;
        r.len      = len;
        r.burst    = AXI_BURST_INCR;
        r.data     = {$urandom, $urandom};
        r.strb     = wr ? 8'hff : 8'h00;
        return r;
    endfunction

    function automatic cbus_resp_t mk_resp(input logic last);
        cbus_resp_t p;
        p.ready = 1'b1;
        p.last  = last;
        p.data  = {$urandom, $urandom};
        return p;
    endfunction

    // Arbitration policy from the rules: lowest valid index, or first valid from the pointer.
    function automatic int pick_ref(input logic [N-1:0] mask);
        int start;
        start = 0;
`ifdef CBUS_ARB_ROUND_ROBIN_EN
        start = tb_ptr;
`endif
        for (int k = 0; k < N; k++) begin
            if (mask[(start + k) % N]) return (start + k) % N;
        end
        return -1;
    endfunction

    task automatic note_grant(input int w);
        tb_ptr = (w + 1) % N;
    endtask

    task automatic apply_reset(input int cycles);
        reset = 1'b0;
        for (int i = 0; i < N; i++) ireqs[i] = '0;
        oresp = '0;
        repeat (cycles) tick();
        reset  = 1'b1;
        tb_ptr = 0;
    endtask

    task automatic test_reset;
        reset = 1'b0;
        for (int i = 0; i < N; i++) ireqs[i] = '0;
        oresp    = '0;
        ireqs[0] = mk_req(1'b0, 32'h8000_0100, 8'd0);
        tick();
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (oreq !== '0) begin errors++; $display("[TB] FAIL reset_oreq got=%h exp=0", oreq); end
        checks++; if (grant_idx !== '0) begin errors++; $display("[TB] FAIL reset_grant got=%0d exp=0", grant_idx); end
        checks++; if (proto_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_proto_err got=%b exp=0", proto_err); end
        checks++; if (iresps[0] !== '0) begin errors++; $display("[TB] FAIL reset_iresp got=%h exp=0", iresps[0]); end
        ireqs[0] = '0;
        reset    = 1'b1;
        tb_ptr   = 0;
        tick();
    endtask

    task automatic test_single_read;
        cbus_req_t r;
        int beats;
        r        = mk_req(1'b0, 32'h8000_1000, 8'd3);
        ireqs[0] = r;
        #1;
        checks++; if (oreq.valid !== 1'b0) begin errors++; $display("[TB] FAIL single_pre_valid got=%b exp=0", oreq.valid); end
        tick();
        checks++; if (oreq !== r) begin errors++; $display("[TB] FAIL single_oreq got=%h exp=%h", oreq, r); end
        checks++; if (grant_idx !== 2'd0 || busy !== 1'b1) begin errors++; $display("[TB] FAIL single_grant got=%0d/%b exp=0/1", grant_idx, busy); end
        note_grant(0);
        beats = 0;
        for (int k = 0; k < 4; k++) begin
            oresp = mk_resp(k == 3);
            #1;
            if (iresps[0].ready) beats++;
            checks++; if (iresps[0] !== oresp) begin errors++; $display("[TB] FAIL single_resp beat=%0d got=%h exp=%h", k, iresps[0], oresp); end
            tick();
        end
        ireqs[0] = '0;
        oresp    = '0;
        #1;
        checks++; if (beats != 4) begin errors++; $display("[TB] FAIL single_beats got=%0d exp=4", beats); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL single_busy_fall got=%b exp=0", busy); end
        checks++; if (proto_err !== 1'b0) begin errors++; $display("[TB] FAIL single_proto got=%b exp=0", proto_err); end
        tick();
    endtask

    task automatic test_simultaneous;
        int first;
        int second;
        for (int round = 0; round < 2; round++) begin
            ireqs[0] = mk_req(1'b1, 32'h8000_2000, 8'd0);
            ireqs[1] = mk_req(1'b1, 32'h8000_3000, 8'd0);
            first    = pick_ref(3'b011);
            second   = 1 - first;
            tick();
            checks++; if (grant_idx !== IW'(first)) begin errors++; $display("[TB] FAIL pair_first r=%0d got=%0d exp=%0d", round, grant_idx, first); end
            note_grant(first);
            oresp = mk_resp(1'b1);
            #1;
            checks++; if (iresps[first].ready !== 1'b1) begin errors++; $display("[TB] FAIL pair_first_ready got=%b exp=1", iresps[first].ready); end
            checks++; if (iresps[second] !== '0) begin errors++; $display("[TB] FAIL pair_wait_resp got=%h exp=0", iresps[second]); end
            tick();
            ireqs[first] = '0;
            oresp        = '0;
            #1;
            checks++; if (busy !== 1'b0 || oreq.valid !== 1'b0) begin errors++; $display("[TB] FAIL pair_gap got=%b/%b exp=0/0", busy, oreq.valid); end
            tick();
            checks++; if (grant_idx !== IW'(second) || busy !== 1'b1) begin errors++; $display("[TB] FAIL pair_second r=%0d got=%0d exp=%0d", round, grant_idx, second); end
            note_grant(second);
            oresp = mk_resp(1'b1);
            tick();
            ireqs[second] = '0;
            oresp         = '0;
            tick();
        end
    endtask

    task automatic test_back_to_back;
        ireqs[0] = mk_req(1'b0, 32'h8000_4000, 8'd7);
        tick();
        note_grant(0);
        for (int k = 0; k < 8; k++) begin
            if (k == 2) ireqs[1] = mk_req(1'b0, 32'h8000_5000, 8'd0);
            oresp = mk_resp(k == 7);
            #1;
            checks++; if (iresps[1] !== '0) begin errors++; $display("[TB] FAIL b2b_waiting_resp beat=%0d got=%h exp=0", k, iresps[1]); end
            tick();
        end
        ireqs[0] = '0;
        oresp    = '0;
        #1;
        checks++; if (grant_idx !== 2'd0 || busy !== 1'b0) begin errors++; $display("[TB] FAIL b2b_idle got=%0d/%b exp=0/0", grant_idx, busy); end
        tick();
        checks++; if (grant_idx !== 2'd1 || busy !== 1'b1) begin errors++; $display("[TB] FAIL b2b_grant1 got=%0d/%b exp=1/1", grant_idx, busy); end
        note_grant(1);
        oresp = mk_resp(1'b1);
        tick();
        ireqs[1] = '0;
        oresp    = '0;
        tick();
    endtask

    task automatic test_stability;
        cbus_req_t r;
        r        = mk_req(1'b0, 32'h8000_0000, 8'd3);
        ireqs[0] = r;
        tick();
        note_grant(0);
        oresp = mk_resp(1'b0);
        #1;
        checks++; if (proto_err !== 1'b0) begin errors++; $display("[TB] FAIL stab_pre got=%b exp=0", proto_err); end
        tick();
        r.addr   = 32'h8000_0040;
        ireqs[0] = r;
        oresp    = '0;
        tick();
        checks++; if (proto_err !== 1'b1) begin errors++; $display("[TB] FAIL stab_set got=%b exp=1", proto_err); end
        for (int k = 1; k < 4; k++) begin
            oresp = mk_resp(k == 3);
            tick();
        end
        ireqs[0] = '0;
        oresp    = '0;
        ireqs[1] = mk_req(1'b1, 32'h8000_0080, 8'd0);
        tick();
        note_grant(1);
        oresp = mk_resp(1'b1);
        tick();
        ireqs[1] = '0;
        oresp    = '0;
        tick();
        checks++; if (proto_err !== 1'b1) begin errors++; $display("[TB] FAIL stab_sticky got=%b exp=1", proto_err); end
        apply_reset(1);
        #1;
        checks++; if (proto_err !== 1'b0) begin errors++; $display("[TB] FAIL stab_cleared got=%b exp=0", proto_err); end
    endtask

    task automatic test_early_last;
        ireqs[0] = mk_req(1'b0, 32'h8000_6000, 8'd3);
        tick();
        note_grant(0);
        oresp = mk_resp(1'b0);
        tick();
        oresp = mk_resp(1'b1);
        tick();
        ireqs[0] = '0;
        oresp    = '0;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL early_busy got=%b exp=0", busy); end
        checks++; if (proto_err !== 1'b1) begin errors++; $display("[TB] FAIL early_proto got=%b exp=1", proto_err); end
        apply_reset(1);
    endtask

    task automatic test_reset_mid;
        cbus_req_t r;
        r        = mk_req(1'b1, 32'h8000_7000, 8'd3);
        ireqs[1] = r;
        tick();
        checks++; if (grant_idx !== 2'd1) begin errors++; $display("[TB] FAIL rmid_grant got=%0d exp=1", grant_idx); end
        note_grant(1);
        oresp = mk_resp(1'b0);
        tick();
        oresp = mk_resp(1'b0);
        tick();
        reset = 1'b0;
        oresp = mk_resp(1'b0);
        tick();
        reset  = 1'b1;
        oresp  = '0;
        tb_ptr = 0;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL rmid_busy got=%b exp=0", busy); end
        checks++; if (oreq !== '0) begin errors++; $display("[TB] FAIL rmid_oreq got=%h exp=0", oreq); end
        checks++; if (grant_idx !== 2'd0) begin errors++; $display("[TB] FAIL rmid_grant_idx got=%0d exp=0", grant_idx); end
        checks++; if (iresps[1] !== '0) begin errors++; $display("[TB] FAIL rmid_iresp got=%h exp=0", iresps[1]); end
        tick();
        checks++; if (grant_idx !== 2'd1 || busy !== 1'b1 || oreq !== r) begin errors++; $display("[TB] FAIL rmid_regrant got=%0d/%b/%h exp=1/1/%h", grant_idx, busy, oreq, r); end
        note_grant(1);
        for (int k = 0; k < 4; k++) begin
            oresp = mk_resp(k == 3);
            tick();
        end
        ireqs[1] = '0;
        oresp    = '0;
        #1;
        checks++; if (proto_err !== 1'b0 || busy !== 1'b0) begin errors++; $display("[TB] FAIL rmid_after got=%b/%b exp=0/0", proto_err, busy); end
        tick();
    endtask

    // Random masters hold a request until they see their last beat; the model tracks owner and pointer.
    task automatic test_random;
        cbus_req_t  m_req  [N];
        logic       m_act  [N];
        int         m_beats[N];
        int         owner;
        int         mem_beats;
        int         w;
        logic [N-1:0] mask;
        cbus_req_t  exp_req;
        cbus_resp_t exp_resp;
        owner     = -1;
        mem_beats = 0;
        for (int i = 0; i < N; i++) begin
            m_act[i]   = 1'b0;
            m_beats[i] = 0;
            m_req[i]   = '0;
        end
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!m_act[i] && $urandom_range(0, 3) == 0) begin
                    m_act[i]   = 1'b1;
                    m_beats[i] = 0;
                    m_req[i]   = mk_req(1'($urandom_range(0, 1)), 32'h8000_0000 + 32'($urandom_range(0, 255)) * 32'd16,
                                        8'($urandom_range(0, 4)));
                end
                ireqs[i] = m_act[i] ? m_req[i] : '0;
            end
            if (owner >= 0 && $urandom_range(0, 2) != 0) oresp = mk_resp(mem_beats == int'(m_req[owner].len));
            else oresp = '0;
            #1;
            exp_req = (owner >= 0) ? ireqs[owner] : '0;
            checks++; if (oreq !== exp_req) begin errors++; $display("[TB] FAIL rand_oreq cyc=%0d got=%h exp=%h", c, oreq, exp_req); end
            checks++; if (busy !== (owner >= 0)) begin errors++; $display("[TB] FAIL rand_busy cyc=%0d got=%b exp=%b", c, busy, owner >= 0); end
            checks++; if (grant_idx !== IW'((owner >= 0) ? owner : 0)) begin errors++; $display("[TB] FAIL rand_grant cyc=%0d got=%0d exp=%0d", c, grant_idx, owner); end
            for (int i = 0; i < N; i++) begin
                exp_resp = (i == owner) ? oresp : '0;
                checks++; if (iresps[i] !== exp_resp) begin errors++; $display("[TB] FAIL rand_iresp cyc=%0d m=%0d got=%h exp=%h", c, i, iresps[i], exp_resp); end
            end
            checks++; if (proto_err !== 1'b0) begin errors++; $display("[TB] FAIL rand_proto cyc=%0d got=%b exp=0", c, proto_err); end
            for (int i = 0; i < N; i++) begin
                if (i == owner && oresp.ready) begin
                    m_beats[i]++;
                    if (oresp.last) begin
                        checks++; if (m_beats[i] != int'(m_req[i].len) + 1) begin errors++; $display("[TB] FAIL rand_beats m=%0d got=%0d exp=%0d", i, m_beats[i], int'(m_req[i].len) + 1); end
                        m_act[i] = 1'b0;
                    end
                end
            end
            if (oresp.ready) mem_beats = oresp.last ? 0 : mem_beats + 1;
            if (owner < 0) begin
                for (int i = 0; i < N; i++) mask[i] = ireqs[i].valid;
                w = pick_ref(mask);
                if (w >= 0) begin
                    owner = w;
                    note_grant(w);
                end
            end else if (oresp.ready && oresp.last) begin
                owner = -1;
            end
            tick();
        end
        for (int i = 0; i < N; i++) ireqs[i] = '0;
        oresp = '0;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        tb_ptr = 0;
        reset  = 1'b0;
        oresp  = '0;
        for (int i = 0; i < N; i++) ireqs[i] = '0;
        test_reset();
        test_single_read();
        test_simultaneous();
        test_back_to_back();
        test_stability();
        test_early_last();
        test_reset_mid();
        apply_reset(1);
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
